lcd_reader: RTL

- Nios II custom-instruction slave that performs one HD44780-style LCD read cycle (rw=1) per start request and returns the sampled byte in result.
- Complement of the team's LCD write instruction; shares the rs/rw/enable/data pads through the board-level bus mux, which this block steers via bus_rd.
- rs=0 reads busy flag + address counter; rs=1 reads DDRAM/CGRAM data. 50 MHz clk, 20 ns per cycle.

---
 rtl/lcd_reader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// HD44780-style LCD read custom instruction: one rw=1 cycle per start, returns the sampled byte.
// Optional busy-flag polling is enabled by defining LCD_BUSY_POLL_EN.
module lcd_reader #(
  parameter int SETUP_CYC   = 3,
  parameter int PULSE_CYC   = 25,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 25,
  parameter int MAX_POLLS   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        done,
  output logic [31:0] result,
  output logic        rs,
  output logic        rw,
  output logic        enable,
  output logic        bus_rd,
  input  logic [7:0]  data_in
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  sample_q;
  logic        done_q;
  logic [31:0] result_q;
  logic        rs_q;
  logic        rw_q;
  logic        en_q;
  logic        bus_rd_q;

  logic [15:0] lim_s;
  logic        last_s;
  logic        repoll_d;
  logic [31:0] result_d;

`ifdef LCD_BUSY_POLL_EN
  logic        poll_q;
  logic [15:0] reads_q;
`endif

  logic unused_s;
  assign unused_s = ^{dataA[31:1], dataB, 16'(MAX_POLLS)};

  // Terminal count of the phase currently being timed
  always_comb begin
    lim_s = 16'h0000;
    case (state_q)
      S_SETUP:   lim_s = 16'(SETUP_CYC - 1);
      S_PULSE:   lim_s = 16'(PULSE_CYC - 1);
      S_HOLD:    lim_s = 16'(HOLD_CYC - 1);
      S_RECOVER: lim_s = 16'(RECOVER_CYC - 1);
      default:   lim_s = 16'h0000;
    endcase
    last_s = (cnt_q == lim_s);
  end

  // Decide at RECOVER exit whether to read again and what the result word is
  always_comb begin
    repoll_d = 1'b0;
    result_d = {24'h000000, sample_q};
`ifdef LCD_BUSY_POLL_EN
    if (poll_q) begin
      // Reaching completion with busy still set can only mean the poll budget ran out
      repoll_d = sample_q[7] && (reads_q < 16'(MAX_POLLS));
      result_d = {reads_q, 7'b0000000, sample_q[7], sample_q};
    end else begin
      repoll_d = 1'b0;
    end
`endif
  end

  // Read-cycle sequencer with registered pad and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'h0000;
      sample_q <= 8'h00;
      done_q   <= 1'b0;
      result_q <= 32'h00000000;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      en_q     <= 1'b0;
      bus_rd_q <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q   <= 1'b0;
      reads_q  <= 16'h0000;
`endif
    end else if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          rw_q     <= 1'b0;
          en_q     <= 1'b0;
          bus_rd_q <= 1'b0;
          cnt_q    <= 16'h0000;
          if (start) begin
            rs_q     <= dataA[0];
            rw_q     <= 1'b1;
            bus_rd_q <= 1'b1;
            state_q  <= S_SETUP;
`ifdef LCD_BUSY_POLL_EN
            poll_q   <= dataA[1] & ~dataA[0];
            reads_q  <= 16'h0000;
`endif
          end
        end
        S_SETUP: begin
          if (last_s) begin
            en_q    <= 1'b1;
            cnt_q   <= 16'h0000;
            state_q <= S_PULSE;
          end else begin
            cnt_q <= cnt_q + 16'h0001;
          end
        end
        S_PULSE: begin
          if (last_s) begin
            sample_q <= data_in;
            en_q     <= 1'b0;
            cnt_q    <= 16'h0000;
            state_q  <= S_HOLD;
`ifdef LCD_BUSY_POLL_EN
            reads_q  <= reads_q + 16'h0001;
`endif
          end else begin
            cnt_q <= cnt_q + 16'h0001;
          end
        end
        S_HOLD: begin
          if (last_s) begin
            rw_q     <= 1'b0;
            bus_rd_q <= 1'b0;
            cnt_q    <= 16'h0000;
            state_q  <= S_RECOVER;
          end else begin
            cnt_q <= cnt_q + 16'h0001;
          end
        end
        S_RECOVER: begin
          if (!last_s) begin
            cnt_q <= cnt_q + 16'h0001;
          end else if (repoll_d) begin
            rw_q     <= 1'b1;
            bus_rd_q <= 1'b1;
            cnt_q    <= 16'h0000;
            state_q  <= S_SETUP;
          end else begin
            done_q   <= 1'b1;
            result_q <= result_d;
            cnt_q    <= 16'h0000;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= 16'h0000;
          rw_q     <= 1'b0;
          en_q     <= 1'b0;
          bus_rd_q <= 1'b0;
        end
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign rs     = rs_q;
  assign rw     = rw_q;
  assign enable = en_q;
  assign bus_rd = bus_rd_q;

endmodule
